// File: rtl/mdu_param.sv
// mdu_param: multi-cycle multiply/divide unit owning HI/LO, with multiply-accumulate,
// mthi/mtlo, a busy stall handshake and abort on exception cancel.
module mdu_param #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int MAXC = MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1) > 5 ? $clog2(MAXC + 1) : 5;
  typedef enum logic {IDLE, BUSY} state_t;
  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;
  logic [3:0]         op_q, op_d;
  logic               done_q, done_d;
  logic [2*WIDTH-1:0] hilo, pu, ps, prod, res;
  logic [WIDTH-1:0]   a_mag, b_mag, uq, ur, quo, rem;
  logic               sgn, a_neg, b_neg, accept, multi, is_div;
  always_comb begin
    hilo  = {hi_q, lo_q};
    sgn   = op_q == 4'd1 || op_q == 4'd3 || op_q == 4'd5 || op_q == 4'd7;
    pu    = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
    ps    = {{WIDTH{a_q[WIDTH-1]}}, a_q} * {{WIDTH{b_q[WIDTH-1]}}, b_q};
    prod  = sgn ? ps : pu;
    a_neg = sgn && a_q[WIDTH-1];
    b_neg = sgn && b_q[WIDTH-1];
    a_mag = a_neg ? -a_q : a_q;
    // divisor forced to 1 on zero so the divider never sees x; result is discarded then
    b_mag = b_q == '0 ? {{(WIDTH-1){1'b0}}, 1'b1} : b_neg ? -b_q : b_q;
    uq    = a_mag / b_mag;
    ur    = a_mag % b_mag;
    quo   = (a_neg ^ b_neg) ? -uq : uq;
    rem   = a_neg ? -ur : ur;
    res   = (op_q == 4'd1 || op_q == 4'd2) ? prod :
            (op_q == 4'd5 || op_q == 4'd6) ? hilo + prod :
            (op_q == 4'd7 || op_q == 4'd8) ? hilo - prod :
            (b_q != '0) ? {rem, quo} : hilo;
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    accept  = state_q == IDLE && start && !cancel;
    multi   = op >= 4'd1 && op <= 4'd8;
    is_div  = op == 4'd3 || op == 4'd4;
    if (accept && multi) begin
      state_d = BUSY;
      a_d     = A;
      b_d     = B;
      op_d    = op;
      cnt_d   = is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
    end else if (accept && op == 4'd9) begin
      hi_d = A;
    end else if (accept && op == 4'd10) begin
      lo_d = A;
    end else if (state_q == BUSY && cancel) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (state_q == BUSY) begin
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == CW'(1)) begin
        state_d      = IDLE;
        {hi_d, lo_d} = res;
        done_d       = 1'b1;
      end
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end
  assign busy = state_q == BUSY;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;
endmodule

// File: tb/tb_mdu_param.sv
// tb_mdu_param: random and directed checks of mdu_param against an arithmetic HI/LO model.
module tb_mdu_param;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        cancel = 1'b0;
  logic [3:0]  op = 4'd0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic        busy, done;
  logic [31:0] hi, lo;
  logic [63:0] m = '0;
  int          checks = 0;
  int          passes = 0;

  always #5 clk = ~clk;

  mdu_param dut (.clk(clk), .reset(reset), .start(start), .op(op), .A(A), .B(B),
                 .cancel(cancel), .busy(busy), .done(done), .hi(hi), .lo(lo));

  function automatic logic [63:0] model(input logic [3:0] o, input logic [31:0] a,
                                        input logic [31:0] b, input logic [63:0] hl);
    longint      sa, sb;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    p  = (o == 1 || o == 5 || o == 7) ? 64'(sa * sb) : {32'b0, a} * {32'b0, b};
    case (o)
      1, 2: return p;
      5, 6: return hl + p;
      7, 8: return hl - p;
      3: begin
        if (b == 0) return hl;
        return {32'(sa % sb), 32'(sa / sb)};
      end
      4: begin
        if (b == 0) return hl;
        return {a % b, a / b};
      end
      9:  return {a, hl[31:0]};
      10: return {hl[63:32], a};
      default: return hl;
    endcase
  endfunction

  function automatic int cycles_for(input logic [3:0] o);
    if (o == 3 || o == 4) return 10;
    if (o >= 1 && o <= 8) return 5;
    return 0;
  endfunction

  task automatic do_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                       output int n, output logic d_fall, output logic d_after);
    @(negedge clk);
    start = 1'b1; op = o; A = a; B = b;
    @(negedge clk);
    start = 1'b0; op = 4'd0;
    n = 0;
    while (busy && n < 200) begin
      n++;
      @(negedge clk);
    end
    d_fall = done;
    @(negedge clk);
    d_after = done;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, hi, lo} !== 66'd0) $display("FAIL reset_state busy=%b done=%b hi=%h lo=%h expected all 0", busy, done, hi, lo);
    else passes++;
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, done} !== 2'b00) $display("FAIL reset_release busy=%b done=%b expected 0 0", busy, done);
    else passes++;
  endtask

  task automatic test_directed();
    logic [3:0]  t_op [12] = '{1, 2, 4, 3, 3, 9, 10, 4, 9, 10, 6, 7};
    logic [31:0] t_a  [12] = '{32'hFFFFFFFD, 32'hFFFFFFFD, 100, 32'hFFFFFFF9, 32'h80000000,
                               32'h12345678, 32'h9ABCDEF0, 32'h0000BEEF, 0, 32'hFFFFFFFF, 1, 1};
    logic [31:0] t_b  [12] = '{7, 7, 7, 2, 32'hFFFFFFFF, 0, 0, 0, 0, 0, 1, 2};
    logic [31:0] t_hi [12] = '{32'hFFFFFFFF, 6, 2, 32'hFFFFFFFF, 0, 32'h12345678, 32'h12345678,
                               32'h12345678, 0, 0, 1, 0};
    logic [31:0] t_lo [12] = '{32'hFFFFFFEB, 32'hFFFFFFEB, 14, 32'hFFFFFFFD, 32'h80000000,
                               32'h80000000, 32'h9ABCDEF0, 32'h9ABCDEF0, 32'h9ABCDEF0,
                               32'hFFFFFFFF, 0, 32'hFFFFFFFE};
    int   n;
    logic df, da;
    for (int i = 0; i < 12; i++) begin
      do_op(t_op[i], t_a[i], t_b[i], n, df, da);
      checks++;
      if (n !== cycles_for(t_op[i])) $display("FAIL dir%0d_busy_cycles got %0d expected %0d", i, n, cycles_for(t_op[i]));
      else passes++;
      checks++;
      if (df !== (t_op[i] <= 8)) $display("FAIL dir%0d_done got %b expected %b", i, df, t_op[i] <= 8);
      else passes++;
      checks++;
      if (da !== 1'b0) $display("FAIL dir%0d_done_width got %b expected 0", i, da);
      else passes++;
      checks++;
      if ({hi, lo} !== {t_hi[i], t_lo[i]}) $display("FAIL dir%0d_hilo got %h_%h expected %h_%h", i, hi, lo, t_hi[i], t_lo[i]);
      else passes++;
      m = {t_hi[i], t_lo[i]};
    end
  endtask

  task automatic test_random();
    int          n;
    logic        df, da;
    logic [3:0]  o;
    logic [31:0] a, b;
    logic [63:0] e;
    for (int i = 0; i < 40; i++) begin
      o = 4'($urandom_range(1, 10));
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 2) == 0) a = $urandom_range(0, 300);
      if ($urandom_range(0, 3) == 0) b = $urandom_range(0, 3);
      if ($urandom_range(0, 7) == 0) b = 32'hFFFFFFFF;
      e = model(o, a, b, m);
      do_op(o, a, b, n, df, da);
      checks++;
      if (n !== cycles_for(o)) $display("FAIL rnd%0d_busy_cycles op=%0d got %0d expected %0d", i, o, n, cycles_for(o));
      else passes++;
      checks++;
      if (df !== (o <= 8) || da !== 1'b0) $display("FAIL rnd%0d_done op=%0d got %b%b expected %b0", i, o, df, da, o <= 8);
      else passes++;
      checks++;
      if ({hi, lo} !== e) $display("FAIL rnd%0d_hilo op=%0d a=%h b=%h got %h_%h expected %h", i, o, a, b, hi, lo, e);
      else passes++;
      m = e;
    end
  endtask

  task automatic test_cancel_busy();
    @(negedge clk);
    start = 1'b1; op = 4'd1; A = 32'd3; B = 32'd5;
    @(negedge clk);
    start = 1'b0; op = 4'd0;
    checks++;
    if (busy !== 1'b1) $display("FAIL cancel_busy_rise got %b expected 1", busy);
    else passes++;
    repeat (2) @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    checks++;
    if ({busy, done} !== 2'b00) $display("FAIL cancel_abort busy=%b done=%b expected 0 0", busy, done);
    else passes++;
    checks++;
    if ({hi, lo} !== m) $display("FAIL cancel_hilo got %h_%h expected %h", hi, lo, m);
    else passes++;
    repeat (6) @(negedge clk);
    checks++;
    if ({busy, done, hi, lo} !== {2'b00, m}) $display("FAIL cancel_late busy=%b done=%b hilo=%h_%h", busy, done, hi, lo);
    else passes++;
  endtask

  task automatic test_start_cancel();
    logic [3:0] ops [3] = '{1, 3, 9};
    logic       seen;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      start = 1'b1; cancel = 1'b1; op = ops[i]; A = $urandom | 32'h1; B = 32'd3;
      @(negedge clk);
      start = 1'b0; cancel = 1'b0; op = 4'd0;
      seen = 1'b0;
      repeat (3) begin
        seen = seen | busy | done;
        @(negedge clk);
      end
      checks++;
      if (seen !== 1'b0) $display("FAIL start_cancel%0d busy_or_done got 1 expected 0", i);
      else passes++;
      checks++;
      if ({hi, lo} !== m) $display("FAIL start_cancel%0d_hilo got %h_%h expected %h", i, hi, lo, m);
      else passes++;
    end
  endtask

  task automatic test_mthi_busy();
    logic [31:0] a, b;
    logic [63:0] e;
    int          n;
    a = $urandom;
    b = $urandom;
    e = model(4'd1, a, b, m);
    @(negedge clk);
    start = 1'b1; op = 4'd1; A = a; B = b;
    @(negedge clk);
    op = 4'd9; A = 32'hA5A5A5A5;
    @(negedge clk);
    start = 1'b0; op = 4'd0;
    checks++;
    if (hi !== m[63:32]) $display("FAIL mthi_busy_hi got %h expected %h", hi, m[63:32]);
    else passes++;
    n = 0;
    while (busy && n < 200) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (n !== 4 || done !== 1'b1) $display("FAIL mthi_busy_done remaining=%0d done=%b expected 4 1", n, done);
    else passes++;
    checks++;
    if ({hi, lo} !== e) $display("FAIL mthi_busy_hilo got %h_%h expected %h", hi, lo, e);
    else passes++;
    m = e;
  endtask

  task automatic test_async_reset();
    int          n;
    logic        df, da;
    logic [31:0] a, b;
    logic [63:0] e;
    do_op(4'd9, 32'hDEADBEEF, 0, n, df, da);
    do_op(4'd10, 32'hCAFEF00D, 0, n, df, da);
    @(negedge clk);
    start = 1'b1; op = 4'd4; A = $urandom; B = 32'd9;
    @(negedge clk);
    start = 1'b0; op = 4'd0;
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({busy, done, hi, lo} !== 66'd0) $display("FAIL async_reset busy=%b done=%b hi=%h lo=%h expected all 0", busy, done, hi, lo);
    else passes++;
    @(negedge clk);
    reset = 1'b1;
    m = '0;
    a = $urandom;
    b = $urandom;
    e = model(4'd1, a, b, m);
    do_op(4'd1, a, b, n, df, da);
    checks++;
    if (n !== 5 || df !== 1'b1 || da !== 1'b0) $display("FAIL post_reset_mult cycles=%0d done=%b%b expected 5 10", n, df, da);
    else passes++;
    checks++;
    if ({hi, lo} !== e) $display("FAIL post_reset_hilo got %h_%h expected %h", hi, lo, e);
    else passes++;
    m = e;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_cancel_busy();
    test_start_cancel();
    test_mthi_busy();
    test_async_reset();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/mdu_param.md
Name: mdu_param

Overview:
- Parametrised multiply/divide unit holding HI/LO for the next-generation MIPS datapath. Sits beside the ALU in the execute stage.
- Adds what the single-cycle ALU lacks: multi-cycle mult/div with a busy handshake for stall logic, signed and unsigned modes, multiply-accumulate, mthi/mtlo, and cancellation by an exception request from CP0.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- MULT_CYCLES, 5, busy cycles for multiply-class ops. Must be >=1.
- DIV_CYCLES, 10, busy cycles for divide-class ops. Must be >=1.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  op valid this cycle.
- op  input  4  operation code, encoding below.
- A  input  WIDTH  rs operand.
- B  input  WIDTH  rt operand.
- cancel  input  1  exception flush (CP0 Req). Aborts or blocks the current op.
- busy  output  1  operation in flight. Stall source.
- done  output  1  one-cycle pulse when HI/LO are committed by a mult/div-class op.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Reset: reset low clears immediately, independent of clk: hi=0, lo=0, busy=0, done=0, state=IDLE, counter=0, latched operands=0. An in-flight op is discarded.
- op encoding: 0 nop, 1 mult, 2 multu, 3 div, 4 divu, 5 madd, 6 maddu, 7 msub, 8 msubu, 9 mthi, 10 mtlo. Codes 11-15 are nop.
- States: IDLE and BUSY. A 5-bit-or-wider down-counter loads on start.
- Accepting a multi-cycle op:
  - In IDLE, at an edge with start=1, cancel=0 and op in 1..8, the unit latches A, B and op.
  - It loads the counter with MULT_CYCLES (ops 1,2,5-8) or DIV_CYCLES (ops 3,4) and enters BUSY.
  - busy goes high after that edge.
- Completion:
  - In BUSY the counter decrements each edge.
  - At the edge where it reaches 0: hi/lo update, busy goes low, done=1 for the following cycle, state returns to IDLE.
  - busy is therefore high for exactly N cycles, and results are visible in the same cycle busy falls.
- mthi/mtlo: in IDLE with start=1 and cancel=0, op 9 writes hi=A and op 10 writes lo=A at that edge. No busy, no done.
- start while BUSY: ignored. The pipeline must stall on busy. This includes mthi/mtlo.
- cancel:
  - start together with cancel is ignored entirely.
  - cancel high in BUSY returns to IDLE at the next edge with busy=0, hi/lo unchanged and no done pulse.
  - cancel in IDLE has no effect.
- Arithmetic, using the latched operands:
  - mult/multu: {hi,lo} = full 2*WIDTH signed or unsigned product.
  - madd(u)/msub(u): {hi,lo} = {hi,lo} +/- product, using the signed or unsigned product, with 2*WIDTH wrap-around. The hi/lo values used are those current at completion.
  - div/divu: lo = quotient, hi = remainder. Signed quotient truncates toward zero, and the remainder takes the dividend's sign.
  - Signed min/-1 (e.g. 0x80000000 / 0xFFFFFFFF): lo=0x80000000, hi=0.
  - Divide by zero: hi/lo unchanged, but the op still takes DIV_CYCLES and done still pulses.
- Results may be computed combinationally and registered at completion. An iterative implementation is also acceptable if it meets the cycle counts exactly.

Test Plan:
- Defaults assumed. mult A=0xFFFFFFFD (-3), B=7 -> busy high exactly 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFEB, done pulses once. multu with the same operands -> hi=0x00000006, lo=0xFFFFFFEB.
- divu 100/7 -> after 10 busy cycles lo=14, hi=2. div 0xFFFFFFF9 (-7) / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. div 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- mthi 0x12345678, mtlo 0x9ABCDEF0, then divu x/0 -> hi/lo keep 0x12345678/0x9ABCDEF0 after 10 cycles, done pulses.
- mthi 0, mtlo 0xFFFFFFFF, maddu 1*1 -> hi=1, lo=0. Then msub 1*2 -> hi=0, lo=0xFFFFFFFE.
- Cancel cases:
  - mult started, cancel asserted in the 3rd busy cycle -> busy low after that edge, hi/lo unchanged, no done.
  - start+cancel in the same cycle -> busy never rises.
  - mthi issued while busy -> hi unaffected.
- Drive reset low asynchronously mid-div (between clock edges) -> busy, hi and lo go to 0 immediately. After release, a new mult completes normally in 5 cycles.
